// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter
//   Round-robin arbiter that shares one 2048x8 font ROM between NUM_REQ
//   glyph-row requesters. One ROM read is issued per cycle. Each accepted
//   request returns one 8-bit row bitmap, tagged with the requester ID,
//   exactly two cycles after acceptance. Character codes that the ROM does
//   not populate are returned as 8'h00.
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_req_valid  per-requester request valid            [NUM_REQ]
//   i_req_code   7-bit character code per requester     [7*NUM_REQ]
//   i_req_row    4-bit glyph row per requester          [4*NUM_REQ]
//   o_req_ready  one-hot grant (accept = valid & ready) [NUM_REQ]
//   o_rom_addr   ROM address {code, row}                [11]
//   i_rom_data   ROM data, valid the cycle after addr   [8]
//   o_rsp_valid  one-hot single-cycle response strobe   [NUM_REQ]
//   o_rsp_id     binary index of responding requester   [ID_W]
//   o_rsp_data   glyph row bitmap, bit 7 = leftmost     [8]

module font_rom_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [7*NUM_REQ-1:0] i_req_code,
    input  logic [4*NUM_REQ-1:0] i_req_row,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [10:0]          o_rom_addr,
    input  logic [7:0]           i_rom_data,
    output logic [NUM_REQ-1:0]   o_rsp_valid,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic [7:0]           o_rsp_data
);

    // Codes actually populated in the font ROM; anything else reads stale data.
    function automatic logic f_blank(input logic [6:0] code);
        logic b;
        case (code)
            7'h00, 7'h2A, 7'h2B, 7'h2D, 7'h2F,
            7'h30, 7'h31, 7'h32, 7'h33, 7'h34,
            7'h35, 7'h36, 7'h37, 7'h38, 7'h39,
            7'h3D:   b = 1'b0;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    logic [ID_W-1:0]    r_last;
    logic [10:0]        r_addr_hold;
    logic               r_v1;
    logic [ID_W-1:0]    r_id1;
    logic               r_blank1;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [7:0]         r_rsp_data;

    logic               w_found;
    logic               w_accept;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [6:0]         w_code;
    logic [3:0]         w_row;
    logic [10:0]        w_rom_addr;
    logic [NUM_REQ-1:0] w_id1_onehot;

    // Round-robin search as two ascending passes: first the indices above
    // last_grant, then the wrapped-around indices up to and including it.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_grant = '0;
        w_code  = '0;
        w_row   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (i > 32'(r_last))) begin
                w_found    = 1'b1;
                w_idx      = ID_W'(i);
                w_grant[i] = 1'b1;
                w_code     = i_req_code[7*i +: 7];
                w_row      = i_req_row[4*i +: 4];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (i <= 32'(r_last))) begin
                w_found    = 1'b1;
                w_idx      = ID_W'(i);
                w_grant[i] = 1'b1;
                w_code     = i_req_code[7*i +: 7];
                w_row      = i_req_row[4*i +: 4];
            end
        end
    end

    assign w_accept    = w_found && !i_reset;
    assign o_req_ready = i_reset ? '0 : w_grant;

    // Address follows the grant combinationally; idle cycles replay the last one.
    assign w_rom_addr = w_accept ? {w_code, w_row} : r_addr_hold;
    assign o_rom_addr = w_rom_addr;

    always_comb begin
        w_id1_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_id1_onehot[i] = (r_id1 == ID_W'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last      <= ID_W'(NUM_REQ - 1);
            r_addr_hold <= '0;
            r_v1        <= 1'b0;
            r_id1       <= '0;
            r_blank1    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_last <= w_idx;
            end
            r_addr_hold <= w_rom_addr;
            // S1: track the read issued this cycle alongside the ROM's own register.
            r_v1        <= w_accept;
            r_id1       <= w_idx;
            r_blank1    <= f_blank(w_code);
            // S2: ROM data is valid now; tag it and blank unpopulated codes.
            r_rsp_valid <= r_v1 ? w_id1_onehot : '0;
            r_rsp_id    <= r_id1;
            r_rsp_data  <= r_blank1 ? 8'h00 : i_rom_data;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter
//   Self-checking bench for font_rom_arbiter (NUM_REQ=2). A behavioural
//   registered ROM drives i_rom_data; unpopulated codes hold non-zero stale
//   contents. Expected responses are queued at grant time and compared when
//   the DUT responds.

module tb_font_rom_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [7*NUM_REQ-1:0] req_code;
    logic [4*NUM_REQ-1:0] req_row;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [10:0]          o_rom_addr;
    logic [7:0]           rom_data;
    logic [NUM_REQ-1:0]   o_rsp_valid;
    logic [ID_W-1:0]      o_rsp_id;
    logic [7:0]           o_rsp_data;

    logic [7:0] rom [0:2047];
    logic [7:0] rom_q = 8'h00;

    int cyc       = 0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
        int              due;
    } exp_t;
    exp_t sb[$];

    font_rom_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_code  (req_code),
        .i_req_row   (req_row),
        .o_req_ready (o_req_ready),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (rom_data),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_data  (o_rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered font ROM: address captured at the edge, data valid next cycle.
    always @(posedge clk) rom_q <= rom[o_rom_addr];
    assign rom_data = rom_q;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_rsp_valid !== '0) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: rsp_valid=%b id=%0d data=%h at cycle %0d, none expected",
                             o_rsp_valid, o_rsp_id, o_rsp_data, cyc);
                end else begin
                    exp_t e;
                    logic [NUM_REQ-1:0] ev;
                    e = sb.pop_front();
                    ev = '0;
                    ev[e.id] = 1'b1;
                    if (o_rsp_valid !== ev || o_rsp_id !== e.id || o_rsp_data !== e.data || cyc != e.due)
                        $display("FAIL sb_rsp: got valid=%b id=%0d data=%h cycle=%0d, expected valid=%b id=%0d data=%h cycle=%0d",
                                 o_rsp_valid, o_rsp_id, o_rsp_data, cyc, ev, e.id, e.data, e.due);
                    else
                        pass_cnt++;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                total_cnt++;
                $display("FAIL sb_missing: rsp_valid=0 at cycle %0d, expected id=%0d data=%h due %0d",
                         cyc, sb[0].id, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] v, input logic [6:0] c0, input logic [3:0] r0,
                         input logic [6:0] c1, input logic [3:0] r1);
        req_valid = v;
        req_code  = {c1, c0};
        req_row   = {r1, r0};
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 7'h30, 4'h2, 7'h38, 4'h6);
        step();
        step();
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b00) $display("FAIL reset_ready: req_ready=%b expected 00", o_req_ready);
        else pass_cnt++;
        total_cnt++;
        if (o_rsp_valid !== 2'b00 || o_rsp_id !== 2'd0 || o_rsp_data !== 8'h00)
            $display("FAIL reset_outputs: valid=%b id=%0d data=%h expected 00/0/00", o_rsp_valid, o_rsp_id, o_rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (o_rom_addr !== 11'h000) $display("FAIL reset_rom_addr: rom_addr=%h expected 000", o_rom_addr);
        else pass_cnt++;
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        apply_reset();
        drive(2'b01, 7'h2B, 4'h7, 7'h00, 4'h0);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b01) $display("FAIL single_ready: req_ready=%b expected 01", o_req_ready);
        else pass_cnt++;
        total_cnt++;
        if (o_rom_addr !== 11'h2B7) $display("FAIL single_rom_addr: rom_addr=%h expected 2b7", o_rom_addr);
        else pass_cnt++;
        push(2'd0, 8'h7E);
        step();
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        step();
        #1;
        total_cnt++;
        if (o_rsp_valid !== 2'b01 || o_rsp_id !== 2'd0 || o_rsp_data !== 8'h7E)
            $display("FAIL single_rsp: valid=%b id=%0d data=%h expected 01/0/7e", o_rsp_valid, o_rsp_id, o_rsp_data);
        else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (o_rsp_valid !== 2'b00) $display("FAIL single_one_cycle: rsp_valid=%b expected 00", o_rsp_valid);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_rdy;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            drive(2'b11, 7'h30, 4'h2, 7'h38, 4'h6);
            #1;
            total_cnt++;
            if (o_req_ready !== exp_rdy) $display("FAIL rr_grant%0d: req_ready=%b expected %b", k, o_req_ready, exp_rdy);
            else pass_cnt++;
            push(ID_W'(k % 2), 8'h7C);
            step();
        end
        drain();
    endtask

    task automatic test_blanking();
        apply_reset();
        drive(2'b01, 7'h2A, 4'h5, 7'h00, 4'h0);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b01) $display("FAIL blank_ready0: req_ready=%b expected 01", o_req_ready);
        else pass_cnt++;
        push(2'd0, 8'h66);
        step();
        drive(2'b10, 7'h00, 4'h0, 7'h41, 4'h5);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b10) $display("FAIL blank_ready1: req_ready=%b expected 10", o_req_ready);
        else pass_cnt++;
        push(2'd1, 8'h00);
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rows [0:9];
        exp_rows = '{8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C};
        apply_reset();
        for (int r = 2; r <= 11; r++) begin
            drive(2'b01, 7'h35, 4'(r), 7'h00, 4'h0);
            #1;
            total_cnt++;
            if (o_req_ready !== 2'b01) $display("FAIL b2b_ready_row%0d: req_ready=%b expected 01", r, o_req_ready);
            else pass_cnt++;
            push(2'd0, exp_rows[r-2]);
            step();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        drive(2'b01, 7'h33, 4'h2, 7'h00, 4'h0);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b01) $display("FAIL mid_grant: req_ready=%b expected 01", o_req_ready);
        else pass_cnt++;
        step();
        rst = 1'b1;
        sb.delete();
        drive(2'b11, 7'h30, 4'h2, 7'h38, 4'h6);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b00) $display("FAIL mid_ready_in_reset: req_ready=%b expected 00", o_req_ready);
        else pass_cnt++;
        step();
        rst = 1'b0;
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        #1;
        total_cnt++;
        if (o_rsp_valid !== 2'b00 || o_rsp_data !== 8'h00 || o_rsp_id !== 2'd0 || o_rom_addr !== 11'h000)
            $display("FAIL mid_dropped: valid=%b id=%0d data=%h rom_addr=%h expected 00/0/00/000",
                     o_rsp_valid, o_rsp_id, o_rsp_data, o_rom_addr);
        else pass_cnt++;
        drive(2'b11, 7'h30, 4'h2, 7'h38, 4'h6);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b01) $display("FAIL mid_first_grant: req_ready=%b expected 01", o_req_ready);
        else pass_cnt++;
        push(2'd0, 8'h7C);
        step();
        drain();
    endtask

    task automatic test_idle_hold();
        apply_reset();
        drive(2'b10, 7'h00, 4'h0, 7'h3D, 4'h4);
        #1;
        total_cnt++;
        if (o_req_ready !== 2'b10) $display("FAIL idle_ready: req_ready=%b expected 10", o_req_ready);
        else pass_cnt++;
        push(2'd1, 8'hFE);
        step();
        drive(2'b00, 7'h00, 4'h0, 7'h00, 4'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (o_rom_addr !== 11'h3D4) $display("FAIL idle_addr%0d: rom_addr=%h expected 3d4", k, o_rom_addr);
            else pass_cnt++;
            if (k >= 2) begin
                total_cnt++;
                if (o_rsp_valid !== 2'b00) $display("FAIL idle_rsp%0d: rsp_valid=%b expected 00", k, o_rsp_valid);
                else pass_cnt++;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 2048; a++) begin
            logic [10:0] aa;
            aa = 11'(a);
            rom[a] = 8'hA5 ^ aa[7:0] ^ {5'b0, aa[10:8]};
            if (rom[a] == 8'h00) rom[a] = 8'h5A;
        end
        rom[11'h2B7] = 8'h7E;
        rom[11'h302] = 8'h7C;
        rom[11'h386] = 8'h7C;
        rom[11'h2A5] = 8'h66;
        rom[11'h415] = 8'h66;
        rom[11'h332] = 8'h7C;
        rom[11'h3D4] = 8'hFE;
        rom[11'h352] = 8'hFE; rom[11'h353] = 8'hC0; rom[11'h354] = 8'hC0;
        rom[11'h355] = 8'hC0; rom[11'h356] = 8'hFC; rom[11'h357] = 8'h06;
        rom[11'h358] = 8'h06; rom[11'h359] = 8'h06; rom[11'h35A] = 8'hC6;
        rom[11'h35B] = 8'h7C;

        test_reset();
        test_single_read();
        test_round_robin();
        test_blanking();
        test_back_to_back();
        test_reset_midflight();
        test_idle_hold();
        drain();

        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d responses outstanding, expected 0", sb.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
